// File: rtl/conv_px_serializer_pkg.sv
// conv_px_serializer_pkg: shared widths, frame constants and state type for the pixel serializer
package conv_px_serializer_pkg;
    localparam int KERNEL_NUM = 24;
    localparam int BITS_Q4_6 = 10;
    localparam int BYTE_W = 8;
    localparam int VEC_W = KERNEL_NUM * BITS_Q4_6;
    localparam int PAYLOAD_BYTES = VEC_W / BYTE_W;
    localparam int K_W = $clog2(PAYLOAD_BYTES);
    localparam logic [BYTE_W-1:0] FRAME_HEADER = 8'hA5;
    typedef logic [KERNEL_NUM-1:0][BITS_Q4_6-1:0] vector_8_Q4_6;
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} ser_state_t;
endpackage

// File: rtl/conv_px_serializer.sv
// conv_px_serializer: captures a Q4.6 result vector and streams it as header, packed payload and XOR checksum bytes
module conv_px_serializer
    import conv_px_serializer_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              px_rdy_i,
    input  vector_8_Q4_6      px_array_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              overrun_o
);
    localparam logic [K_W-1:0] K_LAST = K_W'(PAYLOAD_BYTES - 1);

    if ((VEC_W % BYTE_W) != 0) begin : g_width_check
        $error("KERNEL_NUM*BITS_Q4_6 must be a multiple of BYTE_W");
    end

    ser_state_t        state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic [VEC_W-1:0]  buf_q, buf_d;
    logic              px_rdy_q;
    logic              overrun_q, overrun_d;
    logic [BYTE_W-1:0] pay_byte;
    logic              cap_edge, xfer, capture;

    assign pay_byte     = buf_q[{k_q, 3'b000} +: BYTE_W];
    assign byte_valid_o = state_q != IDLE;
    assign busy_o       = state_q != IDLE;
    assign overrun_o    = overrun_q;
    assign byte_o       = (state_q == HEADER)   ? FRAME_HEADER :
                          (state_q == PAYLOAD)  ? pay_byte :
                          (state_q == CHECKSUM) ? csum_q : '0;

    // Next-state: walk the frame on each transfer; a capture is only taken when idle or as the checksum leaves
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        csum_d    = csum_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        cap_edge  = px_rdy_i & ~px_rdy_q;
        xfer      = byte_valid_o & byte_ready_i;
        capture   = cap_edge & ((state_q == IDLE) | ((state_q == CHECKSUM) & xfer));
        case (state_q)
            HEADER:   if (xfer) state_d = PAYLOAD;
            PAYLOAD:  if (xfer) begin
                csum_d  = csum_q ^ pay_byte;
                k_d     = (k_q == K_LAST) ? '0 : k_q + K_W'(1);
                state_d = (k_q == K_LAST) ? CHECKSUM : PAYLOAD;
            end
            CHECKSUM: if (xfer) state_d = IDLE;
            default:  state_d = state_q;
        endcase
        if (cap_edge & ~capture) overrun_d = 1'b1;
        if (capture) begin
            buf_d   = px_array_i;
            csum_d  = '0;
            k_d     = '0;
            state_d = HEADER;
        end
    end

    // State registers; px_rdy_q resets high so a level already present at release is not an edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            k_q       <= '0;
            csum_q    <= '0;
            buf_q     <= '0;
            px_rdy_q  <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            csum_q    <= csum_d;
            buf_q     <= buf_d;
            px_rdy_q  <= px_rdy_i;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_conv_px_serializer.sv
// tb_conv_px_serializer: randomized frame checks against a byte-level frame model
module tb_conv_px_serializer;
    import conv_px_serializer_pkg::*;

    logic             clk_i = 0, reset_i = 0, px_rdy_i = 0, byte_ready_i = 1;
    logic [VEC_W-1:0] px_array_i = '0;
    logic [7:0]       byte_o;
    logic             byte_valid_o, busy_o, overrun_o;

    int         n_chk = 0, n_pass = 0;
    logic [7:0] got[$];
    int         vcyc, hold6;
    logic       first_valid;

    conv_px_serializer dut (
        .clk_i(clk_i), .reset_i(reset_i), .px_rdy_i(px_rdy_i), .px_array_i(px_array_i),
        .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    // Frame byte i: 0 header, 1..30 payload byte i-1 (LSB-first), 31 XOR of the payload
    function automatic logic [7:0] exp_byte(input logic [VEC_W-1:0] v, input int i);
        logic [7:0] x;
        x = 8'h00;
        if (i == 0) return 8'hA5;
        if (i <= 30) return v[(i-1)*8 +: 8];
        for (int j = 0; j < 30; j++) x ^= v[j*8 +: 8];
        return x;
    endfunction

    function automatic int first_bad(input logic [VEC_W-1:0] v);
        if (got.size() != 32) return 100 + got.size();
        for (int i = 0; i < 32; i++) if (got[i] !== exp_byte(v, i)) return i;
        return -1;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [255:0] t;
        for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
        return t[VEC_W-1:0];
    endfunction

    task automatic run_frame(input logic [VEC_W-1:0] v, input bit pulse, input int stall, input bit rnd,
                             input int inj_at, input logic [VEC_W-1:0] v2, input int stop_at);
        int c, stalled;
        bit inj_done;
        c = 0; stalled = 0; inj_done = 0;
        got.delete(); vcyc = 0; hold6 = 0; first_valid = 0;
        if (pulse) begin
            @(negedge clk_i);
            px_array_i = v;
            px_rdy_i = 1;
        end
        while (got.size() < stop_at && c < 200) begin
            @(negedge clk_i);
            px_rdy_i = 0;
            if (c == 0) first_valid = byte_valid_o;
            c++;
            if (byte_valid_o) begin
                vcyc++;
                if (got.size() == 6) hold6++;
                if (stall > 0 && got.size() == 6 && stalled < stall) begin
                    byte_ready_i = 0;
                    stalled++;
                end else byte_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (!inj_done && got.size() == inj_at) begin
                    px_array_i = v2;
                    px_rdy_i = 1;
                    inj_done = 1;
                end
                if (byte_ready_i) got.push_back(byte_o);
            end
        end
        byte_ready_i = 1;
    endtask

    task automatic test_reset();
        reset_i = 1;
        #1;
        n_chk++; if (byte_o !== 8'h00) $display("FAIL reset_byte: got %h want 00", byte_o); else n_pass++;
        n_chk++; if (byte_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", byte_valid_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_chk++; if (overrun_o !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun_o); else n_pass++;
        repeat (2) @(negedge clk_i);
        reset_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_single_channel();
        logic [VEC_W-1:0] v;
        int r;
        v = '0;
        v[9:0] = 10'h3FF;
        run_frame(v, 1, 0, 0, -1, '0, 32);
        r = first_bad(v);
        n_chk++; if (r !== -1) $display("FAIL single_stream: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (got.size() != 32 || got[1] !== 8'hFF || got[2] !== 8'h03 || got[31] !== 8'hFC)
            $display("FAIL single_literal: got size %0d, p0/p1/cs not FF/03/FC", got.size()); else n_pass++;
        n_chk++; if (first_valid !== 1'b1) $display("FAIL single_latency: header valid %b want 1", first_valid); else n_pass++;
        n_chk++; if (vcyc != 32) $display("FAIL single_vcycles: got %0d want 32", vcyc); else n_pass++;
        @(negedge clk_i);
        n_chk++; if (byte_valid_o !== 1'b0) $display("FAIL single_valid_end: got %b want 0", byte_valid_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_uniform();
        logic [VEC_W-1:0] v;
        int r;
        for (int j = 0; j < KERNEL_NUM; j++) v[j*10 +: 10] = 10'h155;
        run_frame(v, 1, 0, 0, -1, '0, 32);
        r = first_bad(v);
        n_chk++; if (r !== -1) $display("FAIL uniform_stream: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (got.size() != 32 || got[5] !== 8'h55 || got[31] !== 8'h00)
            $display("FAIL uniform_literal: size %0d, payload/checksum not 55/00", got.size()); else n_pass++;
    endtask

    task automatic test_random_frames();
        logic [VEC_W-1:0] v;
        int r;
        for (int n = 0; n < 5; n++) begin
            v = rand_vec();
            run_frame(v, 1, 0, 1, -1, '0, 32);
            r = first_bad(v);
            n_chk++; if (r !== -1) $display("FAIL random_stream%0d: bad index %0d want -1", n, r); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] v;
        int r;
        v = rand_vec();
        run_frame(v, 1, 3, 0, -1, '0, 32);
        r = first_bad(v);
        n_chk++; if (r !== -1) $display("FAIL bp_stream: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (hold6 != 4) $display("FAIL bp_hold: got %0d cycles want 4", hold6); else n_pass++;
        n_chk++; if (vcyc != 35) $display("FAIL bp_vcycles: got %0d want 35", vcyc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [VEC_W-1:0] v1, v2;
        int r;
        v1 = rand_vec();
        v2 = rand_vec();
        run_frame(v1, 1, 0, 0, 31, v2, 32);
        r = first_bad(v1);
        n_chk++; if (r !== -1) $display("FAIL b2b_first: bad index %0d want -1", r); else n_pass++;
        run_frame(v2, 0, 0, 0, -1, '0, 32);
        n_chk++; if (first_valid !== 1'b1) $display("FAIL b2b_no_gap: header valid %b want 1", first_valid); else n_pass++;
        r = first_bad(v2);
        n_chk++; if (r !== -1) $display("FAIL b2b_second: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (overrun_o !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun_o); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [VEC_W-1:0] v1, v2;
        int r, extra;
        v1 = rand_vec();
        v2 = ~v1;
        run_frame(v1, 1, 0, 0, 11, v2, 32);
        r = first_bad(v1);
        n_chk++; if (r !== -1) $display("FAIL ovr_stream: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (overrun_o !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun_o); else n_pass++;
        extra = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (byte_valid_o) extra++;
        end
        n_chk++; if (extra != 0) $display("FAIL ovr_no_second: valid cycles %0d want 0", extra); else n_pass++;
        n_chk++; if (overrun_o !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun_o); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [VEC_W-1:0] v;
        int r, spur;
        v = rand_vec();
        run_frame(v, 1, 0, 0, -1, '0, 13);
        px_rdy_i = 1;
        reset_i = 1;
        #1;
        n_chk++; if ({byte_o, byte_valid_o, busy_o, overrun_o} !== 11'd0)
            $display("FAIL rst_mid_outputs: got byte %h valid %b busy %b ovr %b want all 0",
                     byte_o, byte_valid_o, busy_o, overrun_o); else n_pass++;
        @(negedge clk_i);
        reset_i = 0;
        spur = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (byte_valid_o) spur++;
        end
        n_chk++; if (spur != 0) $display("FAIL rst_no_capture: valid cycles %0d want 0", spur); else n_pass++;
        px_rdy_i = 0;
        v = rand_vec();
        run_frame(v, 1, 0, 0, -1, '0, 32);
        r = first_bad(v);
        n_chk++; if (r !== -1) $display("FAIL rst_clean_frame: bad index %0d want -1", r); else n_pass++;
        n_chk++; if (overrun_o !== 1'b0) $display("FAIL rst_overrun: got %b want 0", overrun_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_uniform();
        test_random_frames();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/conv_px_serializer.md
# conv_px_serializer

Output serializer for the convolution layer. It captures one 24-channel Q4.6 result vector on each rising edge of the layer's pixel-ready strobe. It then streams that vector off-chip as a framed, byte-wide sequence over a valid/ready handshake: one header byte, 30 bit-packed payload bytes and one XOR checksum byte. It sits between the conv layer's `out_px_array`/`px_rdy_o` outputs and the 8-bit output pins.

## Interface
- `KERNEL_NUM`, 24, number of channels in the result vector
- `BITS_Q4_6`, 10, width of one Q4.6 channel value
- `BYTE_W`, 8, output byte width
- `clk_i`  in  1  system clock
- `reset_i`  in  1  reset; one clock; reset is asynchronous and active-high
- `px_rdy_i`  in  1  result-ready level from the conv layer
- `px_array_i`  in  vector_8_Q4_6  24 × 10-bit Q4.6 channel results (p0..p23)
- `byte_o`  out  8  current output byte
- `byte_valid_o`  out  1  `byte_o` holds a valid byte
- `byte_ready_i`  in  1  downstream accepts the byte
- `busy_o`  out  1  a frame is in progress (state ≠ IDLE)
- `overrun_o`  out  1  sticky; a capture edge was dropped because a frame was in progress

## Operation
- **Capture edge:** `px_rdy_i` is high and `px_rdy_q` is low. `px_rdy_q` holds the previous-cycle `px_rdy_i` and resets to 1, so a level that is already high at reset release is not an edge.
- **Capture:** `px_array_i` is latched into a 240-bit buffer. p0 occupies bits [9:0], p1 bits [19:10], …, p23 bits [239:230].
- **States:**
  - IDLE: on a capture edge, latch the buffer and go to HEADER.
  - HEADER: `byte_o` = 8'hA5.
  - PAYLOAD: `byte_o` = buffer bits [8k+7:8k] for k = 0..29 (LSB-first packing).
  - CHECKSUM: `byte_o` = XOR of the 30 payload bytes.
- **Transfer:** occurs when `byte_valid_o && byte_ready_i` on a clock edge.
- **Transitions on transfer:**
  - HEADER → PAYLOAD.
  - PAYLOAD → PAYLOAD with k+1 while k < 29, else → CHECKSUM.
  - CHECKSUM → IDLE.
- **Checksum accumulation:** the checksum register clears on capture and XORs in each payload byte as it transfers.
- `byte_valid_o` = 1 in HEADER, PAYLOAD and CHECKSUM; 0 in IDLE.
- **Capture edge while busy:**
  - If it coincides with the CHECKSUM transfer, it is accepted: the new vector is latched and the state goes straight to HEADER, with no idle cycle.
  - Otherwise the edge is dropped, the buffer is unchanged and `overrun_o` is set. `overrun_o` clears only on reset.
- **Arithmetic:** the Q4.6 values are not interpreted; bits are moved verbatim. `KERNEL_NUM*BITS_Q4_6` must be a multiple of 8; elaboration fails otherwise.

## Timing
- **Reset values:** `byte_o` = 0, `byte_valid_o` = 0, `busy_o` = 0, `overrun_o` = 0. State = IDLE, payload counter k = 0, checksum = 0, buffer = 0.
- **Latency:** edge sampled at clock N → header valid after edge N. With `byte_ready_i` held high, a frame takes 32 cycles, and `byte_valid_o` falls after the CHECKSUM transfer edge.
- **Backpressure:** while `byte_valid_o` = 1 and `byte_ready_i` = 0, `byte_o` and the state hold stable. No byte is skipped or repeated.
- **Registered outputs:** `byte_valid_o` does not depend combinationally on `byte_ready_i`. All outputs are registered or decoded from state only.
- **Reset mid-frame:** the frame is abandoned immediately (asynchronously). The next frame needs a fresh low→high edge on `px_rdy_i` after reset release.
- **Back-to-back:** sustained throughput is one frame per 32 cycles. Edges spaced closer than that, other than the exact CHECKSUM-transfer cycle, set `overrun_o`.

## Structure
- **Shared package (`parameters.svh`):**
  - `FRAME_HEADER` = 8'hA5.
  - `PAYLOAD_BYTES` = `KERNEL_NUM*BITS_Q4_6/8` (30).
  - State enum `ser_state_t` {IDLE, HEADER, PAYLOAD, CHECKSUM}.
  - `vector_8_Q4_6` is already there.
- **Module layout:** one module. The capture buffer is indexed by k with a byte mux rather than shifted. No sub-module is needed.

## Test plan
- **Single channel:** p0 = 10'h3FF, all others 0, `byte_ready_i` = 1. Required stream:
  - A5, FF, 03, then 28 × 00, then FC.
  - `byte_valid_o` high exactly 32 cycles; `busy_o` falls after the last transfer.
- **Uniform pattern:** all channels = 10'h155. Required stream: A5, 30 × 55, checksum 00.
- **Backpressure:** drop `byte_ready_i` for 3 cycles while payload byte k = 5 is presented.
  - `byte_o` is held stable for 4 cycles.
  - The stream is identical to the unstalled stream; total frame = 35 cycles.
- **Overrun:** issue a second `px_rdy_i` edge at payload k = 10.
  - The first frame completes unchanged; `overrun_o` = 1 and stays 1.
  - No second frame follows.
- **Back-to-back:** issue a new edge in the same cycle as the CHECKSUM transfer.
  - The header A5 of the new frame is valid on the next cycle.
  - `overrun_o` stays 0.
- **Reset mid-frame:** assert `reset_i` at payload k = 12.
  - All outputs go to 0 immediately.
  - `px_rdy_i` held high through reset release gives no capture; a low→high edge afterwards starts a clean frame.
